// File: rtl/seg_hex_frame.sv
// Hex-to-seven-segment frame builder: captures a 32-bit value, decodes one digit per cycle
// (MSB first) into a shadow frame, then publishes it with a one-cycle FRAME_VALID strobe.
// Optional leading-zero blanking is enabled by defining SEG_HEX_FRAME_LZB_EN.
module seg_hex_frame (
   input  logic        CLK,
   input  logic        RST,
   input  logic        IN_VALID,
   output logic        IN_READY,
   input  logic [31:0] IN_VALUE,
   input  logic [7:0]  IN_DP,
   output logic [63:0] FRAME,
   output logic        FRAME_VALID
);

   localparam logic [63:0] IDLE_FRAME = 64'h0101_0101_0101_0101;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CONV,
      ST_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [31:0] val_q, val_d;
   logic [7:0]  dp_q, dp_d;
   logic [63:0] shadow_q, shadow_d;
   logic [63:0] frame_q, frame_d;
   logic        fv_q, fv_d;
`ifdef SEG_HEX_FRAME_LZB_EN
   logic        nz_q, nz_d;
`endif

   logic [3:0]  nib;
   logic [6:0]  seg_raw;
   logic [7:0]  seg_byte;

   // Segments upper..center (bits 7..1 of the digit byte); the dot is appended separately.
   function automatic logic [6:0] hex_seg(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'b1111110;
         4'h1: s = 7'b0110000;
         4'h2: s = 7'b1101101;
         4'h3: s = 7'b1111001;
         4'h4: s = 7'b0110011;
         4'h5: s = 7'b1011011;
         4'h6: s = 7'b1011111;
         4'h7: s = 7'b1110000;
         4'h8: s = 7'b1111111;
         4'h9: s = 7'b1111011;
         4'hA: s = 7'b1110111;
         4'hB: s = 7'b0011111;
         4'hC: s = 7'b1001110;
         4'hD: s = 7'b0111101;
         4'hE: s = 7'b1001111;
         default: s = 7'b1000111;
      endcase
      return s;
   endfunction

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 3'd7;
         val_q    <= 32'h0;
         dp_q     <= 8'h0;
         shadow_q <= 64'h0;
         frame_q  <= IDLE_FRAME;
         fv_q     <= 1'b0;
`ifdef SEG_HEX_FRAME_LZB_EN
         nz_q     <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         val_q    <= val_d;
         dp_q     <= dp_d;
         shadow_q <= shadow_d;
         frame_q  <= frame_d;
         fv_q     <= fv_d;
`ifdef SEG_HEX_FRAME_LZB_EN
         nz_q     <= nz_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      val_d    = val_q;
      dp_d     = dp_q;
      shadow_d = shadow_q;
      frame_d  = frame_q;
      fv_d     = 1'b0;
`ifdef SEG_HEX_FRAME_LZB_EN
      nz_d     = nz_q;
`endif
      nib      = val_q[{cnt_q, 2'b00} +: 4];
      seg_raw  = hex_seg(nib);
      seg_byte = {seg_raw, dp_q[cnt_q]};

      case (state_q)
         ST_IDLE: begin
            if (IN_VALID) begin
               val_d   = IN_VALUE;
               dp_d    = IN_DP;
               cnt_d   = 3'd7;
`ifdef SEG_HEX_FRAME_LZB_EN
               nz_d    = 1'b0;
`endif
               state_d = ST_CONV;
            end
         end
         ST_CONV: begin
`ifdef SEG_HEX_FRAME_LZB_EN
            // Blank while no nonzero digit has been seen yet; digit 0 always shows.
            if (!nz_q && (nib == 4'h0) && (cnt_q != 3'd0)) begin
               seg_byte = {7'b0, dp_q[cnt_q]};
            end
            nz_d = nz_q | (nib != 4'h0);
`endif
            shadow_d[{cnt_q, 3'b000} +: 8] = seg_byte;
            if (cnt_q == 3'd0) begin
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         ST_DONE: begin
            frame_d = shadow_q;
            fv_d    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign IN_READY    = (state_q == ST_IDLE);
   assign FRAME       = frame_q;
   assign FRAME_VALID = fv_q;

endmodule
